// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbiter interface: EU result handshakes, branch/flush
// events, and the CDB broadcast slots.
interface cdb_arbiter_if #(
   parameter int N_REQ         = 5,
   parameter int CDB_WIDTH     = 2,
   parameter int EBR_MASK_SIZE = 4,
   parameter int ROB_W         = 5,
   parameter int PRD_W         = 6,
   parameter int LRD_W         = 5,
   parameter int DATA_W        = 32
);
   typedef struct packed {
      logic [ROB_W-1:0]  rob_id;
      logic [PRD_W-1:0]  prd_s;
      logic [LRD_W-1:0]  lrd_s;
      logic [DATA_W-1:0] value;
   } cdb_t;

   logic [N_REQ-1:0]                     eu_valid;
   logic [N_REQ-1:0]                     eu_ready;
   cdb_t [N_REQ-1:0]                     eu_result;
   logic [N_REQ-1:0][EBR_MASK_SIZE-1:0]  eu_ebr_mask;
   cdb_t [CDB_WIDTH-1:0]                 cdb_out;
   logic [CDB_WIDTH-1:0]                 cdb_bc;
   logic                                 late_flush;
   logic                                 bra_done;
   logic                                 bra_mispredict;
   logic [EBR_MASK_SIZE-1:0]             bra_id;

   modport master (
      output eu_valid, eu_result, eu_ebr_mask, late_flush, bra_done, bra_mispredict, bra_id,
      input  eu_ready, cdb_out, cdb_bc
   );

   modport slave (
      input  eu_valid, eu_result, eu_ebr_mask, late_flush, bra_done, bra_mispredict, bra_id,
      output eu_ready, cdb_out, cdb_bc
   );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding register per execution unit, round-robin grant
// of up to CDB_WIDTH holders per cycle onto the broadcast slots, with
// branch-mispredict squash, correct-predict mask clearing and late flush.
module cdb_arbiter #(
   parameter int N_REQ         = 5,
   parameter int CDB_WIDTH     = 2,
   parameter int EBR_MASK_SIZE = 4,
   parameter int ROB_W         = 5,
   parameter int PRD_W         = 6,
   parameter int LRD_W         = 5,
   parameter int DATA_W        = 32
) (
   input  logic          clk,
   input  logic          rst,
   cdb_arbiter_if.slave  bus
);
   typedef struct packed {
      logic [ROB_W-1:0]  rob_id;
      logic [PRD_W-1:0]  prd_s;
      logic [LRD_W-1:0]  lrd_s;
      logic [DATA_W-1:0] value;
   } cdb_t;

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]                     hold_valid;
   cdb_t [N_REQ-1:0]                     hold_data;
   logic [N_REQ-1:0][EBR_MASK_SIZE-1:0]  hold_mask;
   logic [PTR_W-1:0]                     rr_ptr;
   logic [PTR_W-1:0]                     rr_ptr_nxt;

   logic [N_REQ-1:0]                     killed;
   logic [N_REQ-1:0]                     in_kill;
   logic [N_REQ-1:0]                     live;
   logic [N_REQ-1:0]                     granted;
   logic                                 mispredict;
   logic                                 correct;
   logic [EBR_MASK_SIZE-1:0]             clr_bits;

   assign mispredict = bus.bra_done & bus.bra_mispredict;
   assign correct    = bus.bra_done & ~bus.bra_mispredict;
   assign clr_bits   = {EBR_MASK_SIZE{correct}} & bus.bra_id;

   // Per-holder squash detection for held and incoming results; live = grantable.
   always_comb begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
         killed[i]  = hold_valid[i] & mispredict & |(hold_mask[i] & bus.bra_id);
         in_kill[i] = mispredict & |(bus.eu_ebr_mask[i] & bus.bra_id);
         live[i]    = hold_valid[i] & ~killed[i] & ~bus.late_flush;
      end
   end

   // Round-robin scan from rr_ptr; the first CDB_WIDTH live holders fill slots in order.
   always_comb begin
      int unsigned idx;
      int unsigned slot;
      granted     = '0;
      bus.cdb_bc  = '0;
      bus.cdb_out = '0;
      rr_ptr_nxt  = rr_ptr;
      slot        = 0;
      idx         = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = 32'(rr_ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (live[idx] && slot < CDB_WIDTH) begin
            granted[idx]       = 1'b1;
            bus.cdb_bc[slot]   = 1'b1;
            bus.cdb_out[slot]  = hold_data[idx];
            rr_ptr_nxt         = (idx == N_REQ - 1) ? '0 : PTR_W'(idx + 1);
            slot               = slot + 1;
         end
      end
   end

   // A holder can accept when it is empty or is being vacated this cycle.
   always_comb begin
      bus.eu_ready = {N_REQ{~rst & ~bus.late_flush}} & (~hold_valid | granted | killed);
   end

   // Holding registers and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid <= '0;
         hold_data  <= '0;
         hold_mask  <= '0;
         rr_ptr     <= '0;
      end else begin
         // late_flush suppresses all grants, so rr_ptr_nxt equals rr_ptr then.
         rr_ptr <= rr_ptr_nxt;
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.late_flush) begin
               hold_valid[i] <= 1'b0;
            end else if (bus.eu_valid[i] && bus.eu_ready[i]) begin
               // A result squashed on arrival completes its handshake but is not kept.
               hold_valid[i] <= ~in_kill[i];
               hold_data[i]  <= bus.eu_result[i];
               hold_mask[i]  <= bus.eu_ebr_mask[i] & ~clr_bits;
            end else begin
               if (granted[i] || killed[i]) hold_valid[i] <= 1'b0;
               hold_mask[i] <= hold_mask[i] & ~clr_bits;
            end
         end
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a queue-based reference model,
// plus a few directed scenarios with fixed expected values.
module tb_cdb_arbiter;
   localparam int N = 5;
   localparam int W = 2;
   localparam int M = 4;

   typedef struct packed {
      logic [4:0]  rob_id;
      logic [5:0]  prd_s;
      logic [4:0]  lrd_s;
      logic [31:0] value;
   } cdb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   cdb_arbiter_if #(.N_REQ(N), .CDB_WIDTH(W), .EBR_MASK_SIZE(M),
                    .ROB_W(5), .PRD_W(6), .LRD_W(5), .DATA_W(32)) bus ();

   cdb_arbiter #(.N_REQ(N), .CDB_WIDTH(W), .EBR_MASK_SIZE(M),
                 .ROB_W(5), .PRD_W(6), .LRD_W(5), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // reference model state
   bit          m_valid [N];
   cdb_t        m_data  [N];
   logic [M-1:0] m_mask [N];
   int          m_ptr;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_idle();
      bus.eu_valid       = '0;
      bus.eu_result      = '0;
      bus.eu_ebr_mask    = '0;
      bus.late_flush     = 1'b0;
      bus.bra_done       = 1'b0;
      bus.bra_mispredict = 1'b0;
      bus.bra_id         = '0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0;
         m_mask[i]  = '0;
         m_data[i]  = '0;
      end
      m_ptr = 0;
   endtask

   // Compare outputs with the model for the current inputs, advance the model, step a clock.
   task automatic run_cycle();
      int           q[$];
      int           n_g;
      bit           g [N];
      bit           kill;
      bit           hit;
      logic [W-1:0] e_bc;
      cdb_t [W-1:0] e_out;
      logic [N-1:0] e_rdy;
      kill = bus.bra_done && bus.bra_mispredict;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (m_valid[i] && !bus.late_flush && !(kill && (m_mask[i] & bus.bra_id) != 0))
            q.push_back(i);
      end
      n_g   = (q.size() < W) ? q.size() : W;
      e_bc  = '0;
      e_out = '0;
      for (int i = 0; i < N; i++) g[i] = 0;
      for (int s = 0; s < n_g; s++) begin
         e_bc[s]  = 1'b1;
         e_out[s] = m_data[q[s]];
         g[q[s]]  = 1;
      end
      for (int i = 0; i < N; i++) begin
         hit      = kill && (m_mask[i] & bus.bra_id) != 0;
         e_rdy[i] = !bus.late_flush && !(m_valid[i] && !g[i] && !hit);
      end
      chk("cdb_bc",   128'(bus.cdb_bc),   128'(e_bc));
      chk("cdb_out",  128'(bus.cdb_out),  128'(e_out));
      chk("eu_ready", 128'(bus.eu_ready), 128'(e_rdy));
      if (n_g > 0) m_ptr = (q[n_g-1] + 1) % N;
      for (int i = 0; i < N; i++) begin
         if (bus.late_flush) begin
            m_valid[i] = 0;
         end else begin
            hit = kill && (m_mask[i] & bus.bra_id) != 0;
            if (g[i] || hit) m_valid[i] = 0;
            if (bus.bra_done && !bus.bra_mispredict) m_mask[i] = m_mask[i] & ~bus.bra_id;
            if (bus.eu_valid[i] && e_rdy[i]) begin
               if (kill && (bus.eu_ebr_mask[i] & bus.bra_id) != 0) begin
                  m_valid[i] = 0;
               end else begin
                  m_valid[i] = 1;
                  m_data[i]  = bus.eu_result[i];
                  m_mask[i]  = bus.eu_ebr_mask[i]
                             & ~((bus.bra_done && !bus.bra_mispredict) ? bus.bra_id : 4'b0);
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      #4;
      run_cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      #4;
      chk("rst_bc",    128'(bus.cdb_bc),   128'(0));
      chk("rst_ready", 128'(bus.eu_ready), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
   endtask

   task automatic rand_inputs(input int valid_pct, input int flush_pct);
      cdb_t r;
      for (int i = 0; i < N; i++) begin
         r = 48'({$urandom, $urandom});
         bus.eu_valid[i]    = ($urandom_range(0, 99) < valid_pct);
         bus.eu_result[i]   = r;
         bus.eu_ebr_mask[i] = 4'($urandom & $urandom);
      end
      bus.bra_done       = ($urandom_range(0, 3) == 0);
      bus.bra_mispredict = 1'($urandom_range(0, 1));
      bus.bra_id         = 4'(1 << $urandom_range(0, 3));
      bus.late_flush     = ($urandom_range(0, 99) < flush_pct);
   endtask

   initial begin
      cdb_t r;
      drive_idle();
      model_clear();
      @(posedge clk);
      #1;
      do_reset();

      // alu result with rob_id 3 broadcasts on slot 0 one cycle later
      r = '0;
      r.rob_id = 5'd3;
      bus.eu_valid[0]  = 1'b1;
      bus.eu_result[0] = r;
      tick();
      drive_idle();
      #4;
      chk("t1_bc",  128'(bus.cdb_bc),            128'(2'b01));
      chk("t1_rob", 128'(bus.cdb_out[0].rob_id), 128'(3));
      run_cycle();

      // all five EUs at once: {0,1},{2,3},{4}, pointer wraps back to 0
      do_reset();
      for (int i = 0; i < N; i++) begin
         r = '0;
         r.rob_id = 5'(10 + i);
         bus.eu_valid[i]  = 1'b1;
         bus.eu_result[i] = r;
      end
      tick();
      drive_idle();
      #4;
      chk("t2_bc1", 128'(bus.cdb_bc), 128'(2'b11));
      chk("t2_c1",  128'({bus.cdb_out[1].rob_id, bus.cdb_out[0].rob_id}), 128'({5'd11, 5'd10}));
      run_cycle();
      #4;
      chk("t2_c2",  128'({bus.cdb_out[1].rob_id, bus.cdb_out[0].rob_id}), 128'({5'd13, 5'd12}));
      run_cycle();
      #4;
      chk("t2_bc3", 128'(bus.cdb_bc), 128'(2'b01));
      chk("t2_c3",  128'(bus.cdb_out[0].rob_id), 128'(14));
      run_cycle();
      r = '0;
      r.rob_id = 5'd20;
      bus.eu_valid  = 5'b10001;
      bus.eu_result = '0;
      bus.eu_result[0] = r;
      tick();
      drive_idle();
      #4;
      chk("t2_ptr0", 128'(bus.cdb_out[0].rob_id), 128'(20));
      run_cycle();

      // randomized traffic with branch events, flushes and one mid-cycle async reset
      for (int c = 0; c < 3000; c++) begin
         rand_inputs((c % 400 < 200) ? 80 : 40, 4);
         if (c == 1500) begin
            #2;
            rst = 1'b1;
            #1;
            chk("arst_bc",    128'(bus.cdb_bc),   128'(0));
            chk("arst_ready", 128'(bus.eu_ready), 128'(0));
            @(posedge clk);
            #1;
            rst = 1'b0;
            model_clear();
         end else begin
            tick();
         end
      end
      drive_idle();
      for (int c = 0; c < 4; c++) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
